// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the datapath and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Magnitudes are processed unsigned for WIDTH cycles, then sign-corrected in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               rem_neg;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // For division the low half of prod doubles as the dividend/quotient shifter.
  always_comb begin
    signed_op = ~bus.op[0];
    abs_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, prod[WIDTH-1:1]};

    div_shift = {rem[WIDTH-1:0], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = ~div_diff[WIDTH];
    rem_next  = div_ok ? div_diff : div_shift;
    quo_next  = {prod[WIDTH-2:0], div_ok};

    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_fix   = rem_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      prod     <= '0;
      rem      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wd;
          if (bus.lo_we) bus.lo <= bus.wd;
          if (bus.start) begin
            is_div   <= bus.op[1];
            neg_q    <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg  <= signed_op & bus.a[WIDTH-1];
            div_zero <= bus.op[1] & (bus.b == '0);
            a_raw    <= bus.a;
            opnd     <= bus.op[1] ? abs_b : abs_a;
            prod     <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            rem      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            rem  <= rem_next;
            prod <= {prod[2*WIDTH-1:WIDTH], quo_next};
          end else begin
            prod <= mul_next;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            bus.hi <= a_raw;
            bus.lo <= '1;
          end else begin
            bus.hi <= rem_fix;
            bus.lo <= quo_fix;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
